// File: rtl/mem_ctrl_line.sv
// mem_ctrl_line: bridges CPU word reads/writes onto host cache-line transactions.
// Defining MEM_CTRL_LINE_BUF_EN adds a one-line write-back buffer (tag/valid/dirty).

module mem_ctrl_line #(
    parameter int ADDR_BITCOUNT = 64,
    parameter int WORD_SIZE     = 32,
    parameter int CL_SIZE_WIDTH = 512
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      host_init,
    input  logic [1:0]                op,
    input  logic [ADDR_BITCOUNT-1:0]  raw_address,
    input  logic [ADDR_BITCOUNT-1:0]  address_offset,
    input  logic [WORD_SIZE-1:0]      common_data_bus_read_in,
    output logic [WORD_SIZE-1:0]      common_data_bus_write_out,
    input  logic [CL_SIZE_WIDTH-1:0]  host_data_bus_read_in,
    output logic [CL_SIZE_WIDTH-1:0]  host_data_bus_write_out,
    input  logic                      host_rd_ready,
    input  logic                      host_wr_ready,
    output logic                      host_re,
    output logic                      host_we,
    output logic [ADDR_BITCOUNT-1:0]  corrected_address,
    output logic                      ready,
    output logic                      tx_done,
    output logic                      rd_valid
);

    localparam int LINE_BYTES = CL_SIZE_WIDTH / 8;
    localparam int WORDS      = CL_SIZE_WIDTH / WORD_SIZE;
    localparam int WORD_LSB   = $clog2(WORD_SIZE / 8);
    localparam int IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_BITCOUNT-1:0] OFF_MASK = ADDR_BITCOUNT'(LINE_BYTES - 1);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_FLUSH = 2'b11;

    typedef enum logic [2:0] {
        S_UNINIT,
        S_IDLE,
        S_WB,
        S_FETCH,
        S_WT,
        S_DONE
    } state_t;

    function automatic logic [WORD_SIZE-1:0] select_word(
        input logic [CL_SIZE_WIDTH-1:0] line,
        input logic [IDX_W-1:0]         idx
    );
        logic [WORD_SIZE-1:0] w;
        w = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (IDX_W'(k) == idx) w = line[k*WORD_SIZE +: WORD_SIZE];
        end
        return w;
    endfunction

    function automatic logic [CL_SIZE_WIDTH-1:0] merge_word(
        input logic [CL_SIZE_WIDTH-1:0] line,
        input logic [IDX_W-1:0]         idx,
        input logic [WORD_SIZE-1:0]     word
    );
        logic [CL_SIZE_WIDTH-1:0] l;
        l = line;
        for (int k = 0; k < WORDS; k++) begin
            if (IDX_W'(k) == idx) l[k*WORD_SIZE +: WORD_SIZE] = word;
        end
        return l;
    endfunction

    state_t                    state, state_n;
    logic [1:0]                op_q, op_q_n;
    logic [ADDR_BITCOUNT-1:0]  line_addr_q, line_addr_q_n;
    logic [IDX_W-1:0]          idx_q, idx_q_n;
    logic [WORD_SIZE-1:0]      wdata_q, wdata_q_n;

    logic                      ready_n, tx_done_n, rd_valid_n, host_re_n, host_we_n;
    logic [ADDR_BITCOUNT-1:0]  corr_n;
    logic [CL_SIZE_WIDTH-1:0]  wr_out_n;
    logic [WORD_SIZE-1:0]      rdata_n;

    logic [ADDR_BITCOUNT-1:0]  ea, ea_line;
    logic [IDX_W-1:0]          ea_idx;
    logic [CL_SIZE_WIDTH-1:0]  fetch_merged;

    assign ea           = raw_address + address_offset;
    assign ea_line      = ea & ~OFF_MASK;
    assign ea_idx       = (WORDS > 1) ? IDX_W'(ea >> WORD_LSB) : '0;
    assign fetch_merged = merge_word(host_data_bus_read_in, idx_q, wdata_q);

`ifdef MEM_CTRL_LINE_BUF_EN
    logic [CL_SIZE_WIDTH-1:0]  buf_line, buf_line_n;
    logic [ADDR_BITCOUNT-1:0]  buf_tag, buf_tag_n;
    logic                      buf_valid, buf_valid_n;
    logic                      buf_dirty, buf_dirty_n;
    logic                      hit;

    assign hit = buf_valid && (buf_tag == ea_line);
`endif

    always_comb begin
        state_n       = state;
        op_q_n        = op_q;
        line_addr_q_n = line_addr_q;
        idx_q_n       = idx_q;
        wdata_q_n     = wdata_q;
        ready_n       = 1'b0;
        tx_done_n     = 1'b0;
        rd_valid_n    = 1'b0;
        host_re_n     = host_re;
        host_we_n     = host_we;
        corr_n        = corrected_address;
        wr_out_n      = host_data_bus_write_out;
        rdata_n       = common_data_bus_write_out;
`ifdef MEM_CTRL_LINE_BUF_EN
        buf_line_n    = buf_line;
        buf_tag_n     = buf_tag;
        buf_valid_n   = buf_valid;
        buf_dirty_n   = buf_dirty;
`endif

        case (state)
            S_UNINIT: begin
                if (host_init) begin
                    state_n = S_IDLE;
                    ready_n = 1'b1;
                end
            end

            // DONE doubles as an idle cycle so a new op can follow immediately.
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                ready_n = 1'b1;
                if (op != OP_NOP) begin
                    ready_n       = 1'b0;
                    op_q_n        = op;
                    line_addr_q_n = ea_line;
                    idx_q_n       = ea_idx;
                    wdata_q_n     = common_data_bus_read_in;
`ifdef MEM_CTRL_LINE_BUF_EN
                    if (op == OP_FLUSH && !buf_dirty) begin
                        buf_valid_n = 1'b0;
                        state_n     = S_DONE;
                        tx_done_n   = 1'b1;
                        ready_n     = 1'b1;
                    end else if (op != OP_FLUSH && hit) begin
                        state_n   = S_DONE;
                        tx_done_n = 1'b1;
                        ready_n   = 1'b1;
                        if (op == OP_READ) begin
                            rd_valid_n = 1'b1;
                            rdata_n    = select_word(buf_line, ea_idx);
                        end else begin
                            buf_line_n  = merge_word(buf_line, ea_idx, common_data_bus_read_in);
                            buf_dirty_n = 1'b1;
                        end
                    end else if (buf_dirty) begin
                        state_n   = S_WB;
                        host_we_n = 1'b1;
                        corr_n    = buf_tag;
                        wr_out_n  = buf_line;
                    end else begin
                        state_n   = S_FETCH;
                        host_re_n = 1'b1;
                        corr_n    = ea_line;
                    end
`else
                    if (op == OP_FLUSH) begin
                        state_n   = S_DONE;
                        tx_done_n = 1'b1;
                        ready_n   = 1'b1;
                    end else begin
                        state_n   = S_FETCH;
                        host_re_n = 1'b1;
                        corr_n    = ea_line;
                    end
`endif
                end
            end

`ifdef MEM_CTRL_LINE_BUF_EN
            S_WB: begin
                if (host_wr_ready) begin
                    host_we_n   = 1'b0;
                    buf_dirty_n = 1'b0;
                    if (op_q == OP_FLUSH) begin
                        buf_valid_n = 1'b0;
                        state_n     = S_DONE;
                        tx_done_n   = 1'b1;
                        ready_n     = 1'b1;
                    end else begin
                        state_n   = S_FETCH;
                        host_re_n = 1'b1;
                        corr_n    = line_addr_q;
                    end
                end
            end
`endif

            S_FETCH: begin
                if (host_rd_ready) begin
                    host_re_n = 1'b0;
`ifdef MEM_CTRL_LINE_BUF_EN
                    buf_tag_n   = line_addr_q;
                    buf_valid_n = 1'b1;
                    buf_dirty_n = (op_q == OP_WRITE);
                    buf_line_n  = (op_q == OP_WRITE) ? fetch_merged : host_data_bus_read_in;
                    state_n     = S_DONE;
                    tx_done_n   = 1'b1;
                    ready_n     = 1'b1;
                    if (op_q == OP_READ) begin
                        rd_valid_n = 1'b1;
                        rdata_n    = select_word(host_data_bus_read_in, idx_q);
                    end
`else
                    if (op_q == OP_READ) begin
                        state_n    = S_DONE;
                        tx_done_n  = 1'b1;
                        ready_n    = 1'b1;
                        rd_valid_n = 1'b1;
                        rdata_n    = select_word(host_data_bus_read_in, idx_q);
                    end else begin
                        state_n   = S_WT;
                        host_we_n = 1'b1;
                        wr_out_n  = fetch_merged;
                    end
`endif
                end
            end

            S_WT: begin
                if (host_wr_ready) begin
                    host_we_n = 1'b0;
                    state_n   = S_DONE;
                    tx_done_n = 1'b1;
                    ready_n   = 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

    // Reset drops any in-flight host request and discards buffered data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                     <= S_UNINIT;
            op_q                      <= OP_NOP;
            line_addr_q               <= '0;
            idx_q                     <= '0;
            wdata_q                   <= '0;
            ready                     <= 1'b0;
            tx_done                   <= 1'b0;
            rd_valid                  <= 1'b0;
            host_re                   <= 1'b0;
            host_we                   <= 1'b0;
            corrected_address         <= '0;
            host_data_bus_write_out   <= '0;
            common_data_bus_write_out <= '0;
`ifdef MEM_CTRL_LINE_BUF_EN
            buf_line                  <= '0;
            buf_tag                   <= '0;
            buf_valid                 <= 1'b0;
            buf_dirty                 <= 1'b0;
`endif
        end else begin
            state                     <= state_n;
            op_q                      <= op_q_n;
            line_addr_q               <= line_addr_q_n;
            idx_q                     <= idx_q_n;
            wdata_q                   <= wdata_q_n;
            ready                     <= ready_n;
            tx_done                   <= tx_done_n;
            rd_valid                  <= rd_valid_n;
            host_re                   <= host_re_n;
            host_we                   <= host_we_n;
            corrected_address         <= corr_n;
            host_data_bus_write_out   <= wr_out_n;
            common_data_bus_write_out <= rdata_n;
`ifdef MEM_CTRL_LINE_BUF_EN
            buf_line                  <= buf_line_n;
            buf_tag                   <= buf_tag_n;
            buf_valid                 <= buf_valid_n;
            buf_dirty                 <= buf_dirty_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_ctrl_line.sv
// Directed self-checking bench for mem_ctrl_line; outputs sampled on the falling edge.
// Expectations follow MEM_CTRL_LINE_BUF_EN when it is defined for the build.

module tb_mem_ctrl_line;

    localparam int AW = 64;
    localparam int WS = 32;
    localparam int CW = 512;
    localparam int NW = CW / WS;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_FLUSH = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          host_init;
    logic [1:0]    op;
    logic [AW-1:0] raw_address;
    logic [AW-1:0] address_offset;
    logic [WS-1:0] common_data_bus_read_in;
    logic [WS-1:0] common_data_bus_write_out;
    logic [CW-1:0] host_data_bus_read_in;
    logic [CW-1:0] host_data_bus_write_out;
    logic          host_rd_ready;
    logic          host_wr_ready;
    logic          host_re;
    logic          host_we;
    logic [AW-1:0] corrected_address;
    logic          ready;
    logic          tx_done;
    logic          rd_valid;

    int total = 0;
    int bad   = 0;

    mem_ctrl_line #(
        .ADDR_BITCOUNT(AW),
        .WORD_SIZE(WS),
        .CL_SIZE_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .host_init(host_init),
        .op(op),
        .raw_address(raw_address),
        .address_offset(address_offset),
        .common_data_bus_read_in(common_data_bus_read_in),
        .common_data_bus_write_out(common_data_bus_write_out),
        .host_data_bus_read_in(host_data_bus_read_in),
        .host_data_bus_write_out(host_data_bus_write_out),
        .host_rd_ready(host_rd_ready),
        .host_wr_ready(host_wr_ready),
        .host_re(host_re),
        .host_we(host_we),
        .corrected_address(corrected_address),
        .ready(ready),
        .tx_done(tx_done),
        .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] make_line(input logic [31:0] base);
        logic [CW-1:0] l;
        l = '0;
        for (int k = 0; k < NW; k++) l[k*WS +: WS] = base + 32'(k);
        return l;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_op(input logic [1:0] o, input logic [AW-1:0] ra,
                          input logic [AW-1:0] off, input logic [WS-1:0] wd);
        op                      = o;
        raw_address             = ra;
        address_offset          = off;
        common_data_bus_read_in = wd;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; host_init = 1'b0; op = OP_NOP;
        raw_address = '0; address_offset = '0; common_data_bus_read_in = '0;
        host_data_bus_read_in = '0; host_rd_ready = 1'b0; host_wr_ready = 1'b0;
        repeat (10) tick;
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready: got %b want 0", ready); end
        total++; if (host_re !== 1'b0) begin bad++; $display("[TB] FAIL rst_re: got %b want 0", host_re); end
        total++; if (host_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_we: got %b want 0", host_we); end
        total++; if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done: got %b want 0", tx_done); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_rdv: got %b want 0", rd_valid); end
        total++; if (corrected_address !== '0) begin bad++; $display("[TB] FAIL rst_addr: got %h want 0", corrected_address); end
        total++; if (common_data_bus_write_out !== '0) begin bad++; $display("[TB] FAIL rst_rdata: got %h want 0", common_data_bus_write_out); end
        total++; if (host_data_bus_write_out !== '0) begin bad++; $display("[TB] FAIL rst_wline: got %h want 0", host_data_bus_write_out); end
        rst_n = 1'b1;
        repeat (2) tick;
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL uninit_ready: got %b want 0", ready); end
        host_init = 1'b1;
        tick;
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL init_ready: got %b want 1", ready); end
        host_init = 1'b0;
        tick;
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL init_drop_ready: got %b want 1", ready); end
    endtask

    task automatic test_read_miss;
        host_data_bus_read_in = make_line(32'hA000_0000);
        host_rd_ready = 1'b1; host_wr_ready = 1'b1;
        set_op(OP_READ, 64'h1000, 64'h8, 32'h0);
        tick;
        op = OP_NOP; raw_address = 64'hFFFF_0000;
        total++; if (host_re !== 1'b1) begin bad++; $display("[TB] FAIL rm_re: got %b want 1", host_re); end
        total++; if (host_we !== 1'b0) begin bad++; $display("[TB] FAIL rm_we: got %b want 0", host_we); end
        total++; if (corrected_address !== 64'h1000) begin bad++; $display("[TB] FAIL rm_addr: got %h want 1000", corrected_address); end
        total++; if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL rm_early_done: got %b want 0", tx_done); end
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL rm_busy: got %b want 0", ready); end
        tick;
        total++; if (host_re !== 1'b0) begin bad++; $display("[TB] FAIL rm_re_drop: got %b want 0", host_re); end
        total++; if (tx_done !== 1'b1) begin bad++; $display("[TB] FAIL rm_done: got %b want 1", tx_done); end
        total++; if (rd_valid !== 1'b1) begin bad++; $display("[TB] FAIL rm_rdv: got %b want 1", rd_valid); end
        total++; if (common_data_bus_write_out !== 32'hA000_0002) begin bad++; $display("[TB] FAIL rm_data: got %h want a0000002", common_data_bus_write_out); end
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL rm_ready: got %b want 1", ready); end
        tick;
        total++; if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL rm_pulse: got %b want 0", tx_done); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL rm_rdv_pulse: got %b want 0", rd_valid); end
    endtask

    task automatic test_write_rmw;
        logic [CW-1:0] exp_line;
        exp_line = make_line(32'hA000_0000);
        exp_line[1*WS +: WS] = 32'h0000_1234;
        host_data_bus_read_in = make_line(32'hA000_0000);
        host_rd_ready = 1'b1; host_wr_ready = 1'b0;
        set_op(OP_WRITE, 64'h1000, 64'h4, 32'h0000_1234);
        tick;
        op = OP_NOP; common_data_bus_read_in = 32'hFFFF_FFFF;
        total++; if (host_re !== 1'b1) begin bad++; $display("[TB] FAIL wr_re: got %b want 1", host_re); end
        total++; if (host_we !== 1'b0) begin bad++; $display("[TB] FAIL wr_we_early: got %b want 0", host_we); end
        total++; if (corrected_address !== 64'h1000) begin bad++; $display("[TB] FAIL wr_addr: got %h want 1000", corrected_address); end
        tick;
        total++; if (host_re !== 1'b0) begin bad++; $display("[TB] FAIL wr_re_drop: got %b want 0", host_re); end
        total++; if (host_we !== 1'b1) begin bad++; $display("[TB] FAIL wr_we: got %b want 1", host_we); end
        total++; if (corrected_address !== 64'h1000) begin bad++; $display("[TB] FAIL wr_wt_addr: got %h want 1000", corrected_address); end
        total++; if (host_data_bus_write_out !== exp_line) begin bad++; $display("[TB] FAIL wr_line: got %h want %h", host_data_bus_write_out, exp_line); end
        tick;
        total++; if (host_we !== 1'b1) begin bad++; $display("[TB] FAIL wr_stall_we: got %b want 1", host_we); end
        total++; if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL wr_stall_done: got %b want 0", tx_done); end
        host_wr_ready = 1'b1;
        tick;
        total++; if (host_we !== 1'b0) begin bad++; $display("[TB] FAIL wr_we_drop: got %b want 0", host_we); end
        total++; if (tx_done !== 1'b1) begin bad++; $display("[TB] FAIL wr_done: got %b want 1", tx_done); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL wr_rdv: got %b want 0", rd_valid); end
        tick;
    endtask

    task automatic test_write_hit;
        host_rd_ready = 1'b1; host_wr_ready = 1'b1;
        set_op(OP_WRITE, 64'h1000, 64'h4, 32'hDEAD_BEEF);
        tick;
        op = OP_NOP;
        total++; if (tx_done !== 1'b1) begin bad++; $display("[TB] FAIL wh_done: got %b want 1", tx_done); end
        total++; if (host_re !== 1'b0) begin bad++; $display("[TB] FAIL wh_re: got %b want 0", host_re); end
        total++; if (host_we !== 1'b0) begin bad++; $display("[TB] FAIL wh_we: got %b want 0", host_we); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL wh_rdv: got %b want 0", rd_valid); end
        tick;
    endtask

    task automatic test_read_hit;
        set_op(OP_READ, 64'h1000, 64'h4, 32'h0);
        tick;
        op = OP_NOP;
        total++; if (tx_done !== 1'b1) begin bad++; $display("[TB] FAIL rh_done: got %b want 1", tx_done); end
        total++; if (rd_valid !== 1'b1) begin bad++; $display("[TB] FAIL rh_rdv: got %b want 1", rd_valid); end
        total++; if (common_data_bus_write_out !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL rh_data: got %h want deadbeef", common_data_bus_write_out); end
        total++; if (host_re !== 1'b0) begin bad++; $display("[TB] FAIL rh_re: got %b want 0", host_re); end
        tick;
    endtask

    task automatic test_dirty_evict;
        logic [CW-1:0] exp_line;
        exp_line = make_line(32'hA000_0000);
        exp_line[1*WS +: WS] = 32'hDEAD_BEEF;
        host_data_bus_read_in = make_line(32'hB000_0000);
        host_rd_ready = 1'b1; host_wr_ready = 1'b1;
        set_op(OP_READ, 64'h2000, 64'h0, 32'h0);
        tick;
        op = OP_NOP;
        total++; if (host_we !== 1'b1) begin bad++; $display("[TB] FAIL ev_we: got %b want 1", host_we); end
        total++; if (host_re !== 1'b0) begin bad++; $display("[TB] FAIL ev_re_excl: got %b want 0", host_re); end
        total++; if (corrected_address !== 64'h1000) begin bad++; $display("[TB] FAIL ev_wb_addr: got %h want 1000", corrected_address); end
        total++; if (host_data_bus_write_out !== exp_line) begin bad++; $display("[TB] FAIL ev_line: got %h want %h", host_data_bus_write_out, exp_line); end
        tick;
        total++; if (host_we !== 1'b0) begin bad++; $display("[TB] FAIL ev_we_drop: got %b want 0", host_we); end
        total++; if (host_re !== 1'b1) begin bad++; $display("[TB] FAIL ev_re: got %b want 1", host_re); end
        total++; if (corrected_address !== 64'h2000) begin bad++; $display("[TB] FAIL ev_fetch_addr: got %h want 2000", corrected_address); end
        tick;
        total++; if (tx_done !== 1'b1) begin bad++; $display("[TB] FAIL ev_done: got %b want 1", tx_done); end
        total++; if (common_data_bus_write_out !== 32'hB000_0000) begin bad++; $display("[TB] FAIL ev_data: got %h want b0000000", common_data_bus_write_out); end
        tick;
    endtask

    task automatic test_backpressure;
        int re_cycles;
        re_cycles = 0;
        host_data_bus_read_in = make_line(32'hB000_0000);
        host_rd_ready = 1'b0;
        set_op(OP_READ, 64'h3000, 64'h10, 32'h0);
        tick;
        op = OP_NOP;
        if (host_re === 1'b1) re_cycles++;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (host_re === 1'b1) re_cycles++;
            total++; if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL bp_stall_done: got %b want 0", tx_done); end
            if (i == 4) host_rd_ready = 1'b1;
        end
        tick;
        total++; if (re_cycles !== 6) begin bad++; $display("[TB] FAIL bp_re_cycles: got %0d want 6", re_cycles); end
        total++; if (host_re !== 1'b0) begin bad++; $display("[TB] FAIL bp_re_drop: got %b want 0", host_re); end
        total++; if (tx_done !== 1'b1) begin bad++; $display("[TB] FAIL bp_done: got %b want 1", tx_done); end
        total++; if (common_data_bus_write_out !== 32'hB000_0004) begin bad++; $display("[TB] FAIL bp_data: got %h want b0000004", common_data_bus_write_out); end
        tick;
        total++; if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL bp_single: got %b want 0", tx_done); end
    endtask

    task automatic test_flush;
`ifdef MEM_CTRL_LINE_BUF_EN
        logic [CW-1:0] exp_line;
        exp_line = make_line(32'hB000_0000);
        exp_line[2*WS +: WS] = 32'h0000_5555;
        host_wr_ready = 1'b1;
        set_op(OP_WRITE, 64'h3000, 64'h8, 32'h0000_5555);
        tick;
        total++; if (tx_done !== 1'b1) begin bad++; $display("[TB] FAIL fl_wh_done: got %b want 1", tx_done); end
        set_op(OP_FLUSH, 64'h0, 64'h0, 32'h0);
        tick;
        op = OP_NOP;
        total++; if (host_we !== 1'b1) begin bad++; $display("[TB] FAIL fl_we: got %b want 1", host_we); end
        total++; if (corrected_address !== 64'h3000) begin bad++; $display("[TB] FAIL fl_addr: got %h want 3000", corrected_address); end
        total++; if (host_data_bus_write_out !== exp_line) begin bad++; $display("[TB] FAIL fl_line: got %h want %h", host_data_bus_write_out, exp_line); end
        tick;
        total++; if (host_we !== 1'b0) begin bad++; $display("[TB] FAIL fl_we_drop: got %b want 0", host_we); end
        total++; if (tx_done !== 1'b1) begin bad++; $display("[TB] FAIL fl_dirty_done: got %b want 1", tx_done); end
        tick;
`endif
        set_op(OP_FLUSH, 64'h0, 64'h0, 32'h0);
        tick;
        op = OP_NOP;
        total++; if (tx_done !== 1'b1) begin bad++; $display("[TB] FAIL fl_done: got %b want 1", tx_done); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL fl_rdv: got %b want 0", rd_valid); end
        total++; if (host_re !== 1'b0 || host_we !== 1'b0) begin bad++; $display("[TB] FAIL fl_traffic: got re=%b we=%b want 0 0", host_re, host_we); end
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL fl_ready: got %b want 1", ready); end
        tick;
        total++; if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL fl_pulse: got %b want 0", tx_done); end
    endtask

    task automatic test_back_to_back;
        host_data_bus_read_in = make_line(32'hA000_0000);
        host_rd_ready = 1'b1; host_wr_ready = 1'b1;
        set_op(OP_READ, 64'h1000, 64'h0, 32'h0);
        tick;
        op = OP_NOP;
        tick;
        total++; if (common_data_bus_write_out !== 32'hA000_0000) begin bad++; $display("[TB] FAIL bb_data0: got %h want a0000000", common_data_bus_write_out); end
        total++; if (ready !== 1'b1 || tx_done !== 1'b1) begin bad++; $display("[TB] FAIL bb_ready_done: got ready=%b done=%b want 1 1", ready, tx_done); end
        set_op(OP_READ, 64'h1000, 64'h3C, 32'h0);
        tick;
        op = OP_NOP;
`ifndef MEM_CTRL_LINE_BUF_EN
        total++; if (host_re !== 1'b1 || tx_done !== 1'b0) begin bad++; $display("[TB] FAIL bb_second_fetch: got re=%b done=%b want 1 0", host_re, tx_done); end
        tick;
`endif
        total++; if (tx_done !== 1'b1) begin bad++; $display("[TB] FAIL bb_done2: got %b want 1", tx_done); end
        total++; if (common_data_bus_write_out !== 32'hA000_000F) begin bad++; $display("[TB] FAIL bb_data15: got %h want a000000f", common_data_bus_write_out); end
        set_op(OP_FLUSH, 64'h0, 64'h0, 32'h0);
        tick;
        op = OP_NOP;
        total++; if (tx_done !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL bb_flush: got done=%b rdv=%b want 1 0", tx_done, rd_valid); end
        tick;
    endtask

    task automatic test_wrap;
        host_data_bus_read_in = make_line(32'hA000_0000);
        host_rd_ready = 1'b1;
        set_op(OP_READ, 64'hFFFF_FFFF_FFFF_FFF0, 64'h23, 32'h0);
        tick;
        op = OP_NOP;
        total++; if (corrected_address !== 64'h0) begin bad++; $display("[TB] FAIL wrap_addr: got %h want 0", corrected_address); end
        tick;
        total++; if (common_data_bus_write_out !== 32'hA000_0004) begin bad++; $display("[TB] FAIL wrap_data: got %h want a0000004", common_data_bus_write_out); end
        tick;
    endtask

    task automatic test_reset_mid_op;
        host_rd_ready = 1'b0;
        set_op(OP_READ, 64'h5000, 64'h0, 32'h0);
        tick;
        op = OP_NOP;
        total++; if (host_re !== 1'b1) begin bad++; $display("[TB] FAIL rmo_re: got %b want 1", host_re); end
        rst_n = 1'b0;
        tick;
        total++; if (host_re !== 1'b0) begin bad++; $display("[TB] FAIL rmo_re_drop: got %b want 0", host_re); end
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL rmo_ready: got %b want 0", ready); end
        total++; if (corrected_address !== '0) begin bad++; $display("[TB] FAIL rmo_addr: got %h want 0", corrected_address); end
        rst_n = 1'b1; host_init = 1'b0;
        tick;
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL rmo_uninit: got %b want 0", ready); end
        host_init = 1'b1;
        tick;
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL rmo_reinit: got %b want 1", ready); end
    endtask

    initial begin
        test_reset;
        test_read_miss;
`ifdef MEM_CTRL_LINE_BUF_EN
        test_write_hit;
        test_read_hit;
        test_dirty_evict;
`else
        test_write_rmw;
`endif
        test_backpressure;
        test_flush;
        test_back_to_back;
        test_wrap;
        test_reset_mid_op;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
